// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM read arbiter: FSM state enum and the round-robin pick helper.
package ram_arb_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam int MAX_PORTS = 4;

  // One-hot grant of the first set request found scanning from 'start', wrapping at 'n' ports.
  function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                   input logic [1:0]           start,
                                                   input logic [2:0]           n);
    logic [MAX_PORTS-1:0] gnt;
    logic [2:0]           idx;
    gnt = '0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      idx = {1'b0, start} + 3'(k);
      if (idx >= n) idx = idx - n;
      if (3'(k) < n && gnt == '0 && req[idx[1:0]]) gnt[idx[1:0]] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr_q, which moves past the winner on each grant.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int PORTS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [PORTS-1:0] req_i,
  output logic [PORTS-1:0] gnt_o
);

  logic [1:0]           ptr_q, ptr_d;
  logic [MAX_PORTS-1:0] req4, gnt4;

  always_comb begin
    req4            = '0;
    req4[PORTS-1:0] = req_i & {PORTS{en_i}};
    gnt4            = rr_pick(req4, ptr_q, 3'(PORTS));
    ptr_d           = ptr_q;
    for (int i = 0; i < PORTS; i++)
      if (gnt4[i]) ptr_d = (i == PORTS - 1) ? 2'd0 : 2'(i + 1);
  end

  assign gnt_o = gnt4[PORTS-1:0];

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_read_arbiter.sv
// Single-RAM front end: one write port passed through, PORTS read requesters arbitrated round-robin.
// Optional zero-fill sweep after reset is enabled with RAM_READ_ARBITER_INIT_EN.
module ram_read_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WORD_COUNT = 256,
  parameter int WORD_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int PORTS      = 2,
  localparam int AW        = $clog2(WORD_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_busy,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [MASK_WIDTH-1:0] wr_mask,
  input  logic [PORTS-1:0]      rd_req_valid,
  output logic [PORTS-1:0]      rd_req_ready,
  input  logic [PORTS*AW-1:0]   rd_req_addr,
  output logic [PORTS-1:0]      rsp_valid,
  output logic [WORD_WIDTH-1:0] rsp_data,
  output logic                  ram_wr_en,
  output logic [MASK_WIDTH-1:0] ram_wr_mask,
  output logic [AW-1:0]         ram_wr_addr,
  output logic [WORD_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [AW-1:0]         ram_rd_addr,
  input  logic [WORD_WIDTH-1:0] ram_rd_data
);

  logic             run, sweep, wr_fire;
  logic [AW-1:0]    sweep_addr;
  logic [PORTS-1:0] elig, gnt, rsp_valid_q;

`ifdef RAM_READ_ARBITER_INIT_EN
  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == AW'(WORD_COUNT - 1)) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sweep      = (state_q == ST_INIT) && !reset;
  assign run        = (state_q == ST_RUN) && !reset;
  assign sweep_addr = cnt_q;
  assign init_busy  = busy_q;
`else
  assign sweep      = 1'b0;
  assign run        = !reset;
  assign sweep_addr = '0;
  assign init_busy  = 1'b0;
`endif

  assign wr_ready = run;
  assign wr_fire  = wr_valid && run;

  always_comb begin
    ram_wr_en   = wr_fire;
    ram_wr_mask = wr_mask;
    ram_wr_addr = wr_addr;
    ram_wr_data = wr_data;
    if (sweep) begin
      ram_wr_en   = 1'b1;
      ram_wr_mask = '1;
      ram_wr_addr = sweep_addr;
      ram_wr_data = '0;
    end
  end

  // A read colliding with this cycle's write waits one cycle so it sees the new word.
  for (genvar i = 0; i < PORTS; i++) begin : g_elig
    assign elig[i] = rd_req_valid[i] && !(wr_fire && rd_req_addr[i*AW +: AW] == wr_addr);
  end

  rr_arbiter #(.PORTS(PORTS)) u_rr (
    .clk   (clk),
    .reset (reset),
    .en_i  (run),
    .req_i (elig),
    .gnt_o (gnt)
  );

  assign rd_req_ready = gnt;
  assign ram_rd_en    = |gnt;

  always_comb begin
    ram_rd_addr = '0;
    for (int i = 0; i < PORTS; i++)
      if (gnt[i]) ram_rd_addr = rd_req_addr[i*AW +: AW];
  end

  always_ff @(posedge clk) begin
    if (reset) rsp_valid_q <= '0;
    else       rsp_valid_q <= gnt;
  end

  // Reset squashes a response already in its output cycle.
  assign rsp_valid = rsp_valid_q & {PORTS{!reset}};
  assign rsp_data  = ram_rd_data;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Bench for ram_read_arbiter: synchronous RAM model, directed scenarios plus random traffic
// checked against a word-level memory / round-robin reference model.
module tb_ram_read_arbiter;

  localparam int WC = 256;
  localparam int WW = 32;
  localparam int MW = 4;
  localparam int P  = 2;
  localparam int AW = 8;
  localparam int LW = WW / MW;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_busy;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic [MW-1:0] wr_mask;
  logic [P-1:0]  rd_req_valid, rd_req_ready;
  logic [P*AW-1:0] rd_req_addr;
  logic [P-1:0]  rsp_valid;
  logic [WW-1:0] rsp_data;
  logic          ram_wr_en;
  logic [MW-1:0] ram_wr_mask;
  logic [AW-1:0] ram_wr_addr;
  logic [WW-1:0] ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [WW-1:0] ram_rd_data;

  ram_read_arbiter #(.WORD_COUNT(WC), .WORD_WIDTH(WW), .MASK_WIDTH(MW), .PORTS(P)) dut (
    .clk          (clk),
    .reset        (reset),
    .init_busy    (init_busy),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_mask  (ram_wr_mask),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with byte-lane write mask and one-cycle read latency.
  logic [WW-1:0] ram [WC];
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int b = 0; b < MW; b++)
        if (ram_wr_mask[b]) ram[ram_wr_addr][b*LW +: LW] <= ram_wr_data[b*LW +: LW];
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
  end

  // Reference model state
  logic [WW-1:0] mem_m [WC];
  int            rr_m;
  int            pend_m;
  logic [WW-1:0] pend_d;
  int            nvec = 0;
  int            nerr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    wr_mask      = '0;
    rd_req_valid = '0;
    rd_req_addr  = '0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // One RUN-mode cycle: check outputs against the model, then advance the model.
  task automatic run_cycle();
    int            g, idx;
    logic [AW-1:0] a;
    #2;
    check("rsp_valid", rsp_valid, (pend_m >= 0) ? (64'd1 << pend_m) : 64'd0);
    if (pend_m >= 0) check("rsp_data", rsp_data, pend_d);
    check("wr_ready", wr_ready, 1);
    check("ram_wr_en", ram_wr_en, wr_valid);
    if (wr_valid) begin
      check("ram_wr_addr", ram_wr_addr, wr_addr);
      check("ram_wr_data", ram_wr_data, wr_data);
      check("ram_wr_mask", ram_wr_mask, wr_mask);
    end
    g = -1;
    for (int k = 0; k < P; k++) begin
      idx = (rr_m + k) % P;
      a   = rd_req_addr[idx*AW +: AW];
      if (g < 0 && rd_req_valid[idx] && !(wr_valid && a == wr_addr)) g = idx;
    end
    check("rd_req_ready", rd_req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    check("ram_rd_en", ram_rd_en, g >= 0);
    if (g >= 0) begin
      a = rd_req_addr[g*AW +: AW];
      check("ram_rd_addr", ram_rd_addr, a);
      pend_d = mem_m[a];
      rr_m   = (g + 1) % P;
    end
    pend_m = g;
    if (wr_valid)
      for (int b = 0; b < MW; b++)
        if (wr_mask[b]) mem_m[wr_addr][b*LW +: LW] = wr_data[b*LW +: LW];
    next_edge();
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    idle();
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ram_wr_en", ram_wr_en, 0);
    check("rst_ram_rd_en", ram_rd_en, 0);
    check("rst_rd_ready", rd_req_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    pend_m = -1;
    rr_m   = 0;
    next_edge();
  endtask

  // Sweep cycles: check addresses first..first+n-1 while requests are held off.
  task automatic sweep(input int first, input int n);
    for (int c = first; c < first + n; c++) begin
      wr_valid     = 1'b1;
      wr_addr      = AW'($urandom);
      wr_data      = $urandom;
      wr_mask      = '1;
      rd_req_valid = '1;
      #2;
      check("init_busy", init_busy, 1);
      check("sweep_wr_en", ram_wr_en, 1);
      check("sweep_addr", ram_wr_addr, c);
      check("sweep_data", ram_wr_data, 0);
      check("sweep_mask", ram_wr_mask, 4'hF);
      check("sweep_wr_ready", wr_ready, 0);
      check("sweep_rd_ready", rd_req_ready, 0);
      check("sweep_rsp_valid", rsp_valid, 0);
      next_edge();
    end
    idle();
  endtask

  task automatic set_rd(input int port, input logic [AW-1:0] a);
    rd_req_valid[port]          = 1'b1;
    rd_req_addr[port*AW +: AW]  = a;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [WW-1:0] d, input logic [MW-1:0] m);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_mask  = m;
  endtask

  task automatic bring_up();
`ifdef RAM_READ_ARBITER_INIT_EN
    sweep(0, WC);
    #2;
    check("init_done", init_busy, 0);
    for (int a = 0; a < WC; a++) mem_m[a] = '0;
`else
    #2;
    check("init_busy_tied", init_busy, 0);
    for (int a = 0; a < WC; a++) begin
      idle();
      set_wr(AW'(a), '0, '1);
      run_cycle();
    end
    idle();
`endif
  endtask

  initial begin
    pend_m = -1;
    rr_m   = 0;
    reset  = 1'b1;
    idle();
    next_edge();
    reset_cycle();
    reset_cycle();
`ifdef RAM_READ_ARBITER_INIT_EN
    check("rst_init_busy", init_busy, 1);
    reset = 1'b0;
    // Interrupt the sweep at address 100; it must restart from 0.
    sweep(0, 100);
    #2;
    check("sweep_at_100", ram_wr_addr, 100);
    reset_cycle();
`endif
    reset = 1'b0;
    bring_up();

    // Freshly initialised words read back as zero.
    for (int n = 0; n < 40; n++) begin
      idle();
      for (int p = 0; p < P; p++)
        if ($urandom_range(0, 1) == 1) set_rd(p, AW'($urandom));
      run_cycle();
    end

    // Write then read the next cycle.
    idle(); set_wr(8'd5, 32'hDEADBEEF, 4'hF); run_cycle();
    idle(); set_rd(0, 8'd5); run_cycle();
    idle(); #1;
    check("raw_rsp_valid", rsp_valid, 2'b01);
    check("raw_rsp_data", rsp_data, 32'hDEADBEEF);
    run_cycle();

    // Byte-lane merge.
    idle(); set_wr(8'd20, 32'h11223344, 4'hF); run_cycle();
    idle(); set_wr(8'd20, 32'h0000AB00, 4'h2); run_cycle();
    idle(); set_rd(1, 8'd20); run_cycle();
    idle(); #1;
    check("mask_merge", rsp_data, 32'h1122AB44);
    run_cycle();

    // Continuous requests on both ports: alternating grants, back-to-back responses.
    for (int n = 0; n < 8; n++) begin
      idle();
      set_rd(0, AW'(n));
      set_rd(1, 8'd5);
      run_cycle();
    end
    idle(); run_cycle();

    // Collision: port 1 stalls behind the write to its address, port 0 proceeds.
    idle();
    set_wr(8'd9, 32'hCAFE0009, 4'hF);
    set_rd(0, 8'd3);
    set_rd(1, 8'd9);
    #1;
    check("collide_grant", rd_req_ready, 2'b01);
    run_cycle();
    idle(); set_rd(1, 8'd9); #1;
    check("collide_retry", rd_req_ready, 2'b10);
    run_cycle();
    idle(); #1;
    check("collide_data", rsp_data, 32'hCAFE0009);
    run_cycle();

    // Random traffic on a small address window to force collisions.
    for (int n = 0; n < 300; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        set_wr(AW'($urandom_range(0, 7)), $urandom, MW'($urandom));
      for (int p = 0; p < P; p++)
        if ($urandom_range(0, 2) != 0) set_rd(p, AW'($urandom_range(0, 7)));
      run_cycle();
    end

    // Reset in the cycle after a grant drops the response.
    idle(); set_rd(0, 8'd5); run_cycle();
    reset_cycle();
    reset = 1'b0;
`ifdef RAM_READ_ARBITER_INIT_EN
    bring_up();
`endif
    for (int n = 0; n < 6; n++) begin
      idle();
      set_rd(0, 8'd5);
      set_rd(1, 8'd20);
      run_cycle();
    end
    idle(); run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
